genor: RTL and testbench
========================

# genor

Registered parallel-prefix OR ("generate OR") block. Each output bit is the OR of the input bit at that position and all less-significant input bits. The result is registered once. It sits on a data path where a "first set bit and everything above it" mask is needed, for example priority-mask or thermometer generation. The prefix network is combinational and built with a generate loop; only the output stage is clocked.

## Interface
- WIDTH, default 8: data width in bits, ≥ 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-high: asserted = 1 despite the suffix, sampled on rising clk.
- data_in  input  WIDTH  operand vector.
- data_out  output  WIDTH  registered prefix-OR result.

## Operation
- Combinational prefix: p[i] = data_in[i] | data_in[i-1] | … | data_in[0] for i = 0..WIDTH-1.
- p[0] = data_in[0].
- Prefix network is log-depth (Kogge-Stone style):
  - ceil(log2(WIDTH)) stages.
  - At stage s, bit i ORs in the bit at i − 2^s when i ≥ 2^s; otherwise it passes through.
  - Built with generate loops.
  - Result must equal the ripple definition for every input.
- data_out is loaded with p on every rising clk edge when rst_n = 0.
- There is no enable; the block is always updating.
- Properties of the result:
  - It is a monotone "thermometer" toward the MSB: once a bit is 1, all higher bits are 1.
  - data_in = 0 gives data_out = 0.
  - Any input with a set bit at position k gives ones from k to WIDTH-1 and zeros below k, where k is the lowest set bit.
- X/Z on data_in is not handled specially.

## Timing
- Latency: 1 clock. The result for data_in sampled at edge n appears on data_out after edge n.
- Reset:
  - rst_n = 1 at a rising edge forces data_out = 0 at that edge.
  - Reset overrides any data_in.
  - There is no asynchronous path; data_out holds its value between edges even while rst_n rises.
- Reset mid-stream: the output clears on the first edge with rst_n = 1. Normal loading resumes on the first edge with rst_n = 0, with no extra bubble.
- Value after power-up before the first reset edge is unspecified. Benches must apply reset first.
- The combinational path is data_in → prefix network → flop D. Depth is ceil(log2(WIDTH)) OR levels.

## Structure
- No shared package required. WIDTH is a module parameter only.
- The prefix stage level count is a local constant computed with $clog2(WIDTH).
- One optional sub-module, genor_prefix: a purely combinational log-depth prefix-OR network, parameterized by WIDTH.
- genor wraps genor_prefix with the output register and reset.

## Test plan
- Reset: hold rst_n = 1 for 2 edges with data_in = FF → data_out = 00.
- data_in = AA with rst_n = 0 → data_out = FE one edge later.
- data_in = 55 → data_out = FF next edge.
- Patterns, each one edge apart:
  - 00 → 00
  - 80 → 80
  - 01 → FF
  - 10 → F0
  - 3C → FC
- Reset mid-stream: data_in = 55 steady, assert rst_n for one edge → data_out = 00 on that edge. Deassert → FF on the following edge.
- Exhaustive/random, for WIDTH = 8 and additionally WIDTH = 1, 5, 13: compare data_out against the ripple reference model delayed one cycle. Check every edge, including after reset.

Source files
------------

// File: rtl/genor_pkg.sv
// Shared constants and helpers for the genor prefix-OR block.
// Stage-count helper keeps the top and prefix network agreeing on depth.
package genor_pkg;

    localparam int unsigned DefaultWidth = 8;

    // Number of doubling stages needed to span WIDTH bits; zero for a single bit.
    function automatic int unsigned prefix_levels(input int unsigned width);
        return (width <= 1) ? 0 : $clog2(width);
    endfunction

endpackage

// File: rtl/genor_prefix.sv
// Combinational log-depth (Kogge-Stone style) prefix-OR network.
// Bit i of prefix is the OR of data_in[i:0].
module genor_prefix
    import genor_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] prefix
);

    localparam int unsigned Levels = prefix_levels(WIDTH);

    for (genvar s = 0; s < Levels; s++) begin : g_stage
        logic [WIDTH-1:0] in_v;
        logic [WIDTH-1:0] out_v;

        if (s == 0) begin : g_first
            assign in_v = data_in;
        end else begin : g_chain
            assign in_v = g_stage[s-1].out_v;
        end

        // Span doubles each stage: bit i picks up the partial OR ending 2^s below it.
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= (1 << s)) begin : g_or
                assign out_v[i] = in_v[i] | in_v[i-(1<<s)];
            end else begin : g_pass
                assign out_v[i] = in_v[i];
            end
        end
    end

    if (Levels == 0) begin : g_no_stage
        assign prefix = data_in;
    end else begin : g_out
        assign prefix = g_stage[Levels-1].out_v;
    end

endmodule

// File: rtl/genor.sv
// Registered prefix-OR: data_out[i] = |data_in[i:0], one clock of latency.
// rst_n is an active-high synchronous clear despite its name.
module genor
    import genor_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] prefix;

    genor_prefix #(
        .WIDTH(WIDTH)
    ) u_prefix (
        .data_in(data_in),
        .prefix (prefix)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            data_out <= '0;
        end else begin
            data_out <= prefix;
        end
    end

endmodule

// File: tb/tb_genor.sv
// Scoreboard bench for genor at WIDTH 8, 1, 5 and 13 driven from one stimulus word.
// Expected values come from a lowest-set-bit mask model, checked one edge later.
module tb_genor;

    typedef struct {
        logic [7:0]  e8;
        logic [0:0]  e1;
        logic [4:0]  e5;
        logic [12:0] e13;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [12:0] din = '0;

    logic [7:0]  out8;
    logic [0:0]  out1;
    logic [4:0]  out5;
    logic [12:0] out13;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    always #5 clk = ~clk;

    genor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .data_in(din[7:0]), .data_out(out8)
    );
    genor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(din[0:0]), .data_out(out1)
    );
    genor #(.WIDTH(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .data_in(din[4:0]), .data_out(out5)
    );
    genor #(.WIDTH(13)) u_dut13 (
        .clk(clk), .rst_n(rst_n), .data_in(din[12:0]), .data_out(out13)
    );

    // Ones from the lowest set bit up to width-1, zero if the input is zero.
    function automatic logic [31:0] model(input logic [31:0] v, input int w);
        logic [31:0] mask;
        logic [31:0] vm;
        logic [31:0] low;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        vm   = v & mask;
        if (vm == 0) return 32'd0;
        low  = vm & (~vm + 32'd1);
        return mask & ~(low - 32'd1);
    endfunction

    task automatic drive(input logic rst, input logic [12:0] d);
        exp_t e;
        logic [31:0] t;
        @(negedge clk);
        rst_n = rst;
        din   = d;
        t = rst ? 32'd0 : model({19'd0, d}, 8);  e.e8  = t[7:0];
        t = rst ? 32'd0 : model({19'd0, d}, 1);  e.e1  = t[0:0];
        t = rst ? 32'd0 : model({19'd0, d}, 5);  e.e5  = t[4:0];
        t = rst ? 32'd0 : model({19'd0, d}, 13); e.e13 = t[12:0];
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every edge produces a result; compare it against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("w8",  {24'd0, out8},  {24'd0, e.e8});
                cmp("w1",  {31'd0, out1},  {31'd0, e.e1});
                cmp("w5",  {27'd0, out5},  {27'd0, e.e5});
                cmp("w13", {19'd0, out13}, {19'd0, e.e13});
            end
        end
    end

    initial begin
        logic [7:0] pats[5];
        pats = '{8'h00, 8'h80, 8'h01, 8'h10, 8'h3C};

        drive(1'b1, 13'h0FF);
        drive(1'b1, 13'h1FFF);
        drive(1'b0, 13'h0AA);
        drive(1'b0, 13'h055);
        foreach (pats[i]) drive(1'b0, {5'(i * 7), pats[i]});

        // Mid-stream reset on a steady input.
        drive(1'b0, 13'h055);
        drive(1'b1, 13'h055);
        drive(1'b0, 13'h055);
        drive(1'b0, 13'h055);

        for (int n = 0; n < 400; n++) begin
            logic [12:0] r;
            logic        rr;
            r  = 13'($urandom);
            // Sparse inputs exercise the high-bit thermometer boundaries more often.
            if ($urandom_range(0, 3) == 0) r = 13'd1 << $urandom_range(0, 12);
            if ($urandom_range(0, 7) == 0) r = '0;
            rr = ($urandom_range(0, 19) == 0);
            drive(rr, r);
        end

        for (int n = 0; n < 5 && exp_q.size() > 0; n++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
